mac_psum_accum: RTL

- Downstream stage of the 8-lane signed dot-product MAC (19-bit psum, 2-cycle latency).
- Accumulates a group of consecutive psums, one per input tile, into one wide signed result.
- Buffers finished results in a small FIFO with a valid/ready output.
- Issues in_ready to the operand feeder so that no completed result is ever dropped.

---
 rtl/mac_psum_accum.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mac_psum_accum.sv
// mac_psum_accum: accumulates groups of signed MAC psums into saturating
// wide results and queues them in a small FIFO with valid/ready output.
//   clk, reset         : clock, asynchronous active-high reset
//   in_valid/in_last   : operand tile presented to the MAC / tile closes group
//   in_ready           : tile may be accepted this cycle (FIFO space reserved)
//   mac_psum           : MAC result, valid MAC_LAT cycles after an accepted tile
//   out_valid/out_ready: result FIFO head handshake
//   out_data/out_ovf/out_tiles : head result, saturation flag, psum count
module mac_psum_accum #(
    parameter int unsigned PSUM_W     = 19,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned MAC_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8,
    parameter bit          RELU       = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] mac_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_tiles
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + MAC_LAT + 1);
    localparam int unsigned SUM_W  = ACC_W + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state, state_nx;
    logic [MAC_LAT-1:0] dly_v, dly_l;
    logic               d_valid, d_last, fire, push, pop;
    logic [ACC_W-1:0]   acc, acc_nx, base;
    logic [SUM_W-1:0]   sum_w;
    logic               grp_ovf, ovf_nx, pos_ovf, neg_ovf;
    logic [CNT_W-1:0]   tiles, tiles_nx;
    logic [OCC_W-1:0]   occ;

    logic [ACC_W-1:0]   mem_d [FIFO_DEPTH];
    logic               mem_o [FIFO_DEPTH];
    logic [CNT_W-1:0]   mem_t [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]  fifo_cnt;

    assign d_valid = dly_v[MAC_LAT-1];
    assign d_last  = dly_l[MAC_LAT-1];
    assign fire    = in_valid & in_ready;
    assign push    = d_valid & d_last;
    assign pop     = out_valid & out_ready;

    // Reserve a FIFO slot for every group-closing tile still inside the MAC.
    always_comb begin
        occ = OCC_W'(fifo_cnt);
        for (int i = 0; i < int'(MAC_LAT); i++) begin
            occ = occ + OCC_W'(dly_l[i]);
        end
        in_ready = (occ < OCC_W'(FIFO_DEPTH));
    end

    // Tracks which accepted tiles have a psum arriving MAC_LAT cycles later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_v <= '0;
            dly_l <= '0;
        end else begin
            dly_v[0] <= fire;
            dly_l[0] <= fire & in_last;
            for (int i = 1; i < int'(MAC_LAT); i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_l[i] <= dly_l[i-1];
            end
        end
    end

    // Group-control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: a closing psum returns to IDLE, any other psum is mid-group.
    always_comb begin
        state_nx = state;
        if (d_valid) begin
            state_nx = d_last ? IDLE : ACCUM;
        end
    end

    // Saturating accumulate; sum is one bit wider so overflow shows in the top two bits.
    always_comb begin
        base     = (state == IDLE) ? '0 : acc;
        sum_w    = SUM_W'({base[ACC_W-1], base})
                 + SUM_W'({{(SUM_W - PSUM_W){mac_psum[PSUM_W-1]}}, mac_psum});
        pos_ovf  = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
        neg_ovf  =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
        if (pos_ovf)      acc_nx = {1'b0, {(ACC_W-1){1'b1}}};
        else if (neg_ovf) acc_nx = {1'b1, {(ACC_W-1){1'b0}}};
        else              acc_nx = sum_w[ACC_W-1:0];
        ovf_nx   = ((state == ACCUM) & grp_ovf) | pos_ovf | neg_ovf;
        if (state == IDLE)                 tiles_nx = CNT_W'(1);
        else if (tiles == {CNT_W{1'b1}})   tiles_nx = tiles;
        else                               tiles_nx = tiles + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            grp_ovf <= 1'b0;
            tiles   <= '0;
        end else if (d_valid) begin
            acc     <= acc_nx;
            grp_ovf <= d_last ? 1'b0 : ovf_nx;
            tiles   <= tiles_nx;
        end
    end

    // Result FIFO; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_d[i] <= '0;
                mem_o[i] <= 1'b0;
                mem_t[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr] <= acc_nx;
                mem_o[wr_ptr] <= ovf_nx;
                mem_t[wr_ptr] <= tiles_nx;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_ovf   = mem_o[rd_ptr];
    assign out_tiles = mem_t[rd_ptr];
    // ReLU only masks the presented value; the stored result is untouched.
    assign out_data  = (RELU && mem_d[rd_ptr][ACC_W-1]) ? '0 : mem_d[rd_ptr];

    // The in_ready reservation must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_cnt == FCNT_W'(FIFO_DEPTH))));

endmodule
